// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and bubble gating of control fields.
module ex_mem_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned M_W    = 2,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   ctlwb_in,
  input  logic [M_W-1:0]    ctlm_in,
  input  logic [DATA_W-1:0] adder_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [REG_W-1:0]  muxout_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   ctlwb_out,
  output logic [M_W-1:0]    ctlm_out,
  output logic [DATA_W-1:0] adder_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [REG_W-1:0]  muxout_out
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] adder;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata2;
    logic [REG_W-1:0]  rd;
  } entry_t;

  // State bits are {main_v, skid_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  entry_t in_e, main_q, skid_q;
  logic   main_v, skid_v;
  logic   accept, retire;
  logic   ld_main_in, ld_main_skid, ld_skid;

  assign main_v = state_q[1];
  assign skid_v = state_q[0];

  assign in_e = '{wb: ctlwb_in, m: ctlm_in, adder: adder_in,
                  alu: alu_result_in, rdata2: rdata2_in, rd: muxout_in};

  // Ready: registered-only in skid mode, pass-through of out_ready otherwise
  generate
    if (SKID != 0) begin : g_skid_rdy
      assign in_ready = !skid_v;
    end else begin : g_flow_rdy
      assign in_ready = !main_v || out_ready;
    end
  endgenerate

  assign accept = in_valid && in_ready;
  assign retire = main_v && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush squashes everything held or arriving
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !retire)      state_d = FULL;
        else if (!accept && retire) state_d = EMPTY;
      end
      FULL:    if (retire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Data-load controls; a flush leaves data registers untouched
  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY: ld_main_in = accept;
        ONE: begin
          ld_main_in = accept && retire;
          ld_skid    = (SKID != 0) && accept && !retire;
        end
        FULL:    ld_main_skid = retire;
        default: ;
      endcase
    end
  end

  // Main and skid payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_e;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_e;
    end
  end

  // Head entry; control fields gated so a bubble never writes anything
  assign out_valid      = main_v;
  assign ctlwb_out      = main_v ? main_q.wb : '0;
  assign ctlm_out       = main_v ? main_q.m  : '0;
  assign adder_out      = main_q.adder;
  assign alu_result_out = main_q.alu;
  assign rdata2_out     = main_q.rdata2;
  assign muxout_out     = main_q.rd;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg: table-driven SKID=1 instance plus a
// hand-written sequence for the SKID=0 instance.
module tb_ex_mem_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SKID=1 instance signals
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  ctlwb_in, ctlm_in, ctlwb_out, ctlm_out;
  logic [31:0] adder_in, alu_result_in, rdata2_in;
  logic [31:0] adder_out, alu_result_out, rdata2_out;
  logic [4:0]  muxout_in, muxout_out;

  // SKID=0 instance signals
  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [1:0]  ctlwb_in0, ctlm_in0, ctlwb_out0, ctlm_out0;
  logic [31:0] adder_in0, alu_result_in0, rdata2_in0;
  logic [31:0] adder_out0, alu_result_out0, rdata2_out0;
  logic [4:0]  muxout_in0, muxout_out0;

  ex_mem_stage_reg #(.SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
    .adder_in(adder_in), .alu_result_in(alu_result_in),
    .rdata2_in(rdata2_in), .muxout_in(muxout_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out),
    .adder_out(adder_out), .alu_result_out(alu_result_out),
    .rdata2_out(rdata2_out), .muxout_out(muxout_out)
  );

  ex_mem_stage_reg #(.SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .ctlwb_in(ctlwb_in0), .ctlm_in(ctlm_in0),
    .adder_in(adder_in0), .alu_result_in(alu_result_in0),
    .rdata2_in(rdata2_in0), .muxout_in(muxout_in0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .ctlwb_out(ctlwb_out0), .ctlm_out(ctlm_out0),
    .adder_out(adder_out0), .alu_result_out(alu_result_out0),
    .rdata2_out(rdata2_out0), .muxout_out(muxout_out0)
  );

  typedef struct {
    logic       r, f, iv, ordy;
    logic [7:0] alu;
    logic [1:0] wb, m;
    logic       ov, ir;
    logic [7:0] ealu;
    logic [1:0] ewb, em;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, f, iv, ordy, input logic [7:0] alu,
                              input logic [1:0] wb, m, input logic ov, ir,
                              input logic [7:0] ealu, input logic [1:0] ewb, em);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.ordy = ordy; v.alu = alu; v.wb = wb; v.m = m;
    v.ov = ov; v.ir = ir; v.ealu = ealu; v.ewb = ewb; v.em = em;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Other data fields are derived from the ALU value so zero maps to zero
  task automatic drive(input logic [7:0] a);
    alu_result_in = {24'h0, a};
    adder_in      = {20'h0, a, 4'h0};
    rdata2_in     = {16'h0, a, 8'h0};
    muxout_in     = a[4:0];
  endtask

  task automatic drive0(input logic [7:0] a);
    alu_result_in0 = {24'h0, a};
    adder_in0      = {20'h0, a, 4'h0};
    rdata2_in0     = {16'h0, a, 8'h0};
    muxout_in0     = a[4:0];
  endtask

  initial begin
    logic [31:0] ea;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctlwb_in = 2'b00; ctlm_in = 2'b00; drive(8'h00);
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    ctlwb_in0 = 2'b01; ctlm_in0 = 2'b10; drive0(8'h00);

    //              r  f  iv or alu    wb m  | ov ir ealu  ewb em
    // Reset held two cycles with live inputs, then first accept
    vt.push_back(mk(1, 0, 1, 1, 8'h55, 3, 3, 0, 1, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 1, 1, 8'h55, 3, 3, 0, 1, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'h5A, 1, 2, 1, 1, 8'h5A, 1, 2));
    // Streaming 0x10..0x17
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(0, 0, 1, 1, 8'(8'h10 + k), 1, 1, 1, 1, 8'(8'h10 + k), 1, 1));
    // Backpressure: FULL, stall, drain in order
    vt.push_back(mk(0, 0, 1, 0, 8'h18, 1, 1, 1, 0, 8'h17, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 8'h19, 1, 1, 1, 0, 8'h17, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 8'h19, 1, 1, 1, 0, 8'h17, 1, 1));
    vt.push_back(mk(0, 0, 1, 1, 8'h19, 1, 1, 1, 1, 8'h18, 1, 1));
    vt.push_back(mk(0, 0, 1, 1, 8'h19, 1, 1, 1, 1, 8'h19, 1, 1));
    vt.push_back(mk(0, 0, 0, 1, 8'h00, 1, 1, 0, 1, 8'h19, 0, 0));
    // Bubble gating, out_ready while empty, no load when in_valid=0
    vt.push_back(mk(0, 0, 1, 0, 8'h77, 3, 2, 1, 1, 8'h77, 3, 2));
    vt.push_back(mk(0, 0, 0, 0, 8'h88, 3, 2, 1, 1, 8'h77, 3, 2));
    vt.push_back(mk(0, 0, 0, 1, 8'h88, 3, 2, 0, 1, 8'h77, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 8'h99, 3, 3, 0, 1, 8'h77, 0, 0));
    // Flush from FULL with a concurrent entry C
    vt.push_back(mk(0, 0, 1, 0, 8'hA1, 1, 1, 1, 1, 8'hA1, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 8'hB2, 1, 1, 1, 0, 8'hA1, 1, 1));
    vt.push_back(mk(0, 1, 1, 0, 8'hC3, 1, 1, 0, 1, 8'hA1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 8'hC3, 1, 1, 0, 1, 8'hA1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'hD4, 2, 1, 1, 1, 8'hD4, 2, 1));
    vt.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, 1, 8'hD4, 0, 0));
    // Reset mid-stall loses both entries and clears data
    vt.push_back(mk(0, 0, 1, 0, 8'hE5, 1, 1, 1, 1, 8'hE5, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 8'hE6, 1, 1, 1, 0, 8'hE5, 1, 1));
    vt.push_back(mk(1, 0, 1, 0, 8'hE7, 1, 1, 0, 1, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst = vt[i].r; flush = vt[i].f; in_valid = vt[i].iv; out_ready = vt[i].ordy;
      ctlwb_in = vt[i].wb; ctlm_in = vt[i].m; drive(vt[i].alu);
      @(posedge clk);
      #1;
      ea = {24'h0, vt[i].ealu};
      chk($sformatf("v%0d_out_valid", i), {31'h0, out_valid}, {31'h0, vt[i].ov});
      chk($sformatf("v%0d_in_ready", i), {31'h0, in_ready}, {31'h0, vt[i].ir});
      chk($sformatf("v%0d_alu", i), alu_result_out, ea);
      chk($sformatf("v%0d_adder", i), adder_out, ea << 4);
      chk($sformatf("v%0d_rdata2", i), rdata2_out, ea << 8);
      chk($sformatf("v%0d_muxout", i), {27'h0, muxout_out}, {27'h0, vt[i].ealu[4:0]});
      chk($sformatf("v%0d_ctlwb", i), {30'h0, ctlwb_out}, {30'h0, vt[i].ewb});
      chk($sformatf("v%0d_ctlm", i), {30'h0, ctlm_out}, {30'h0, vt[i].em});
    end

    // SKID=0: combinational ready follows out_ready with one held entry
    @(negedge clk);
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    #1;
    chk("s0_empty_ready", {31'h0, in_ready0}, 32'd1);
    chk("s0_empty_valid", {31'h0, out_valid0}, 32'd0);
    in_valid0 = 1'b1; drive0(8'h31);
    @(posedge clk);
    #1;
    chk("s0_held_valid", {31'h0, out_valid0}, 32'd1);
    chk("s0_held_alu", alu_result_out0, 32'h31);
    chk("s0_held_ctlwb", {30'h0, ctlwb_out0}, 32'd1);
    chk("s0_held_ctlm", {30'h0, ctlm_out0}, 32'd2);
    chk("s0_stall_ready", {31'h0, in_ready0}, 32'd0);
    @(negedge clk);
    in_valid0 = 1'b1; out_ready0 = 1'b1; drive0(8'h32);
    #1;
    chk("s0_same_cycle_ready", {31'h0, in_ready0}, 32'd1);
    @(posedge clk);
    #1;
    chk("s0_accept_valid", {31'h0, out_valid0}, 32'd1);
    chk("s0_accept_alu", alu_result_out0, 32'h32);
    chk("s0_accept_adder", adder_out0, 32'h320);
    chk("s0_accept_muxout", {27'h0, muxout_out0}, 32'h12);
    @(negedge clk);
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    chk("s0_drain_valid", {31'h0, out_valid0}, 32'd0);
    chk("s0_drain_ctlwb", {30'h0, ctlwb_out0}, 32'd0);
    chk("s0_drain_ctlm", {30'h0, ctlm_out0}, 32'd0);
    chk("s0_drain_alu_hold", alu_result_out0, 32'h32);
    chk("s0_drain_rdata2_hold", rdata2_out0, 32'h3200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
